pool_ctrl: RTL and testbench
============================

# pool_ctrl

Sequencer for the 2×2 / stride-2 max-pool datapath. It captures the feature-map geometry at `start` and tracks row, column and channel-group counters over the input AXIS stream. For every accepted input beat it issues one command (LOAD or MAX) at a row-buffer address to the pool datapath, and flags which commands produce an output word and which one is the final output. It sits between the APB register block (`start`/`done`/config) and the pool datapath/row buffer, and owns the start/done handshake.

## Interface
- `ADDR_W`, default 12: row-buffer address width. Must satisfy 2^ADDR_W ≥ (flen/2)·G.
- `clk`  in  1: clock; all logic is on its rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `start`  in  1: level from APB; a run begins on the rising edge seen in IDLE.
- `cfg_flen`  in  6: feature-map side length; sampled at start.
- `cfg_inch`  in  9: input channel count; sampled at start.
- `done`  out  1: run finished; held high until `start` is low.
- `err`  out  1: config or stream error in the last run; cleared at the next start.
- `s_valid`  in  1: input AXIS TVALID.
- `s_last`  in  1: input AXIS TLAST.
- `s_ready`  out  1: input AXIS TREADY.
- `cmd_valid`  out  1: command to the datapath.
- `cmd_ready`  in  1: the datapath can accept a command (includes output backpressure).
- `cmd_op`  out  1: 0 = LOAD (write data), 1 = MAX (write max(buf, data)).
- `cmd_addr`  out  ADDR_W: row-buffer word address.
- `cmd_emit`  out  1: the datapath must also send the result on M_AXIS.
- `cmd_last`  out  1: the emitted word is the final output (M_AXIS TLAST).
- `dp_idle`  in  1: the datapath pipeline and output register are empty.

## Operation
- Data format: 4 × 8-bit channels per 32-bit word. G = cfg_inch>>2 words per pixel.
- Input order: g innermost, then col, then row.
- Config is valid when cfg_flen is even and ≥ 2, and cfg_inch[1:0] = 0 with cfg_inch ≥ 4.
  - Invalid config: set `err`, go directly to DONE, accept no beats.
- State machine:
  - IDLE → RUN on a rising edge of `start` with valid config. Latch flen and G, clear counters and `err`.
  - RUN → DRAIN on the handshake of the final beat (row = flen-1, col = flen-1, g = G-1).
  - RUN → DRAIN early on a handshake with `s_last`=1 on a non-final beat; set `err`.
  - DRAIN → DONE when `dp_idle`=1.
  - DONE → IDLE when `start`=0.
- `s_ready` = (state==RUN) & `cmd_ready`. `cmd_valid` = (state==RUN) & `s_valid`. Handshake = `s_valid` & `s_ready`.
- Per beat at position (row, col, g):
  - `cmd_op` = 0 if row is even and col is even; otherwise 1.
  - `cmd_addr` = (col>>1)·G + g. Generate it incrementally from a pixel-pair base register; no multiplier.
  - `cmd_emit` = row odd & col odd.
  - `cmd_last` = `cmd_emit` & final beat.
- Counter update on handshake:
  - g wraps G-1 → 0 and increments col.
  - col wraps flen-1 → 0 and increments row.
  - base advances by G after each odd col and returns to 0 at col wrap.
- A missing `s_last` on the final beat is not an error.
- Output count per run = (flen/2)²·G.

## Timing
- Reset values: `s_ready`=0, `cmd_valid`=0, `cmd_op`=0, `cmd_addr`=0, `cmd_emit`=0, `cmd_last`=0, `done`=0, `err`=0. State=IDLE, all counters 0.
- Command outputs are combinational from registered counters. Counters update on the clock edge after a handshake, so a sustained 1 beat/cycle is supported.
- Start: the first `s_ready` can be high in the cycle after the cycle in which the `start` edge is sampled.
- `done` rises 1 cycle after `dp_idle` is seen in DRAIN. It falls 1 cycle after `start`=0 is sampled in DONE.
- `start` held high in DONE does not restart a run. A new rising edge is required.
- `cmd_ready`=0 stalls: the counters hold and the command outputs stay stable while `s_valid` is held.
- `rstn` low at any time aborts the run: every output returns to its reset value asynchronously, with no `done` pulse.

## Test plan
- flen=2, inch=4 (G=1), 4 beats → ops LOAD, MAX, MAX, MAX; addr 0,0,0,0; emit only on beat 4, with `cmd_last`=1. `done`=1 after `dp_idle`; `done`=0 one cycle after `start` drops.
- flen=4, inch=8 (G=2), 32 beats → row0 addrs 0,1,0,1,2,3,2,3; ops LOAD on even cols, MAX otherwise. 8 emits; `cmd_last` only on beat 32; `err`=0.
- Same run with `cmd_ready` toggled at random, ~50% low → identical command sequence, no beat lost or duplicated, `s_ready` low whenever `cmd_ready` is low.
- flen=4, inch=4 with `s_last`=1 on beat 7 → `err`=1, beats after 7 not accepted (`s_ready`=0), `done`=1 after `dp_idle`.
- Invalid config cfg_flen=3 or cfg_inch=6 → `err`=1 and `done`=1 within 2 cycles; `s_ready` never asserts.
- `rstn` pulsed low mid-run at beat 10 → all outputs are 0 immediately; after reset release a fresh run with flen=2, inch=4 completes normally.

Source files
------------

// File: rtl/pool_ctrl.sv
// pool_ctrl: sequencer for the 2x2 / stride-2 max-pool datapath.
// Latches geometry at start, walks (row, col, group) over the input AXIS stream
// and issues one LOAD/MAX command per accepted beat, flagging emitting and final
// commands. Owns the start/done handshake with the register block.
// Ports:
//   clk, rstn               clock, async active-low reset
//   start, cfg_flen, cfg_inch  run request and geometry (sampled at start)
//   done, err               run finished / config or stream error
//   s_valid, s_last, s_ready   input AXIS handshake
//   cmd_valid, cmd_ready    command handshake to the datapath
//   cmd_op, cmd_addr, cmd_emit, cmd_last  command payload
//   dp_idle                 datapath fully drained
module pool_ctrl #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [5:0]        cfg_flen,
    input  logic [8:0]        cfg_inch,
    output logic              done,
    output logic              err,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_emit,
    output logic              cmd_last,
    input  logic              dp_idle
);

    localparam int unsigned FLEN_W = 6;
    localparam int unsigned GRP_W  = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                start_prev_q, start_prev_d;
    logic [FLEN_W-1:0]   flen_q, flen_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [FLEN_W-1:0]   row_q, row_d;
    logic [FLEN_W-1:0]   col_q, col_d;
    logic [GRP_W-1:0]    g_q, g_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic run, hs, start_rise, cfg_ok, g_wrap, col_wrap, final_beat;

    // Stream/command handshake and per-beat command decode
    assign run        = (state_q == S_RUN);
    assign s_ready    = run & cmd_ready;
    assign cmd_valid  = run & s_valid;
    assign hs         = s_valid & s_ready;

    assign g_wrap     = (g_q == grp_q - GRP_W'(1));
    assign col_wrap   = (col_q == flen_q - FLEN_W'(1));
    assign final_beat = g_wrap & col_wrap & (row_q == flen_q - FLEN_W'(1));

    assign cmd_op     = row_q[0] | col_q[0];
    assign cmd_addr   = base_q + ADDR_W'(g_q);
    assign cmd_emit   = row_q[0] & col_q[0];
    assign cmd_last   = cmd_emit & final_beat;

    assign done       = done_q;
    assign err        = err_q;

    assign start_rise = start & ~start_prev_q;
    // Even side >= 2 and a whole, non-zero number of 4-channel words
    assign cfg_ok     = ~cfg_flen[0] & (cfg_flen != 6'd0) &
                        (cfg_inch[1:0] == 2'd0) & (cfg_inch != 9'd0);

    // Next-state, counter and flag logic
    always_comb begin
        state_d      = state_q;
        start_prev_d = start;
        flen_d       = flen_q;
        grp_d        = grp_q;
        row_d        = row_q;
        col_d        = col_q;
        g_d          = g_q;
        base_d       = base_q;
        err_d        = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    row_d  = '0;
                    col_d  = '0;
                    g_d    = '0;
                    base_d = '0;
                    if (cfg_ok) begin
                        flen_d  = cfg_flen;
                        grp_d   = cfg_inch[8:2];
                        err_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (hs) begin
                    if (g_wrap) begin
                        g_d = '0;
                        if (col_wrap) begin
                            col_d  = '0;
                            row_d  = row_q + FLEN_W'(1);
                            base_d = '0;
                        end else begin
                            col_d = col_q + FLEN_W'(1);
                            // Odd column closes a pixel pair: next pair's base
                            if (col_q[0]) base_d = base_q + ADDR_W'(grp_q);
                        end
                    end else begin
                        g_d = g_q + GRP_W'(1);
                    end
                    if (final_beat) begin
                        state_d = S_DRAIN;
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (dp_idle) state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE);
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            flen_q       <= '0;
            grp_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            g_q          <= '0;
            base_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            flen_q       <= flen_d;
            grp_q        <= grp_d;
            row_q        <= row_d;
            col_q        <= col_d;
            g_q          <= g_d;
            base_q       <= base_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// Testbench for pool_ctrl: randomized stream/backpressure against a loop-based
// reference model; a scoreboard monitor checks every accepted command.
`timescale 1ns/1ps
module tb_pool_ctrl;

    localparam int unsigned ADDR_W = 12;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic              emit;
        logic              last;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [5:0]        cfg_flen = 6'd0;
    logic [8:0]        cfg_inch = 9'd0;
    logic              done, err;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              cmd_valid;
    logic              cmd_ready = 1'b1;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_emit, cmd_last;
    logic              dp_idle = 1'b1;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;
    cmd_t model_q[$];
    cmd_t exp_q[$];

    pool_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_flen(cfg_flen), .cfg_inch(cfg_inch),
        .done(done), .err(err),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_emit(cmd_emit), .cmd_last(cmd_last),
        .dp_idle(dp_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: one command per input pixel word, in row/col/group order
    task automatic build_model(input int flen, input int inch);
        int grp, n, idx;
        cmd_t e;
        grp = inch / 4;
        n   = flen * flen * grp;
        idx = 0;
        model_q.delete();
        for (int r = 0; r < flen; r++)
            for (int c = 0; c < flen; c++)
                for (int g = 0; g < grp; g++) begin
                    e.op   = !((r % 2 == 0) && (c % 2 == 0));
                    e.addr = ADDR_W'((c / 2) * grp + g);
                    e.emit = (r % 2 == 1) && (c % 2 == 1);
                    e.last = e.emit && (idx == n - 1);
                    model_q.push_back(e);
                    idx++;
                end
    endtask

    task automatic start_run(input int flen, input int inch);
        cfg_flen = 6'(flen);
        cfg_inch = 9'(inch);
        dp_idle  = 1'b0;
        start    = 1'b1;
        build_model(flen, inch);
    endtask

    // Offer n beats, pushing each expected command as it is presented
    task automatic drive_beats(input int n, input int last_at);
        bit got;
        for (int b = 0; b < n; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                step();
            end
            s_valid = 1'b1;
            s_last  = (b == last_at);
            exp_q.push_back(model_q[b]);
            got = 1'b0;
            for (int t = 0; t < 500 && !got; t++) begin
                @(negedge clk);
                if (s_ready) got = 1'b1;
                step();
            end
            if (!got) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_timeout: beat %0d not accepted within 500 cycles", b);
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_run(input bit exp_err);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) step();
        chk("done_in_drain", 32'(done), 32'd0);
        dp_idle = 1'b1;
        step();
        chk("done_rise", 32'(done), 32'd1);
        chk("err_at_done", 32'(err), 32'(exp_err));
        repeat (2) step();
        chk("done_held", 32'(done), 32'd1);
        chk("no_restart", 32'(s_ready), 32'd0);
        start = 1'b0;
        step();
        chk("done_fall", 32'(done), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_cmd"}, 32'({cmd_op, cmd_addr, cmd_emit, cmd_last}), 32'd0);
    endtask

    task automatic invalid_cfg(input int flen, input int inch);
        cfg_flen = 6'(flen);
        cfg_inch = 9'(inch);
        start    = 1'b1;
        s_valid  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("inv_s_ready", 32'(s_ready), 32'd0);
        end
        chk("inv_done", 32'(done), 32'd1);
        chk("inv_err", 32'(err), 32'd1);
        step();
        start   = 1'b0;
        s_valid = 1'b0;
        step();
        chk("inv_done_fall", 32'(done), 32'd0);
        chk("inv_err_kept", 32'(err), 32'd1);
    endtask

    // Random command backpressure
    initial forever begin
        @(posedge clk);
        #1;
        cmd_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Scoreboard monitor: samples on the falling edge, mid-cycle
    initial begin
        cmd_t got_c, held, e;
        bit   stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall_prev = 1'b0;
            end else begin
                got_c = '{op: cmd_op, addr: cmd_addr, emit: cmd_emit, last: cmd_last};
                if (!cmd_ready) chk("s_ready_gated", 32'(s_ready), 32'd0);
                if (s_valid && s_ready) begin
                    chk("cmd_valid_hs", 32'(cmd_valid), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got cmd 0x%0h expected none", got_c);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd", 32'(got_c), 32'(e));
                    end
                    stall_prev = 1'b0;
                end else if (cmd_valid && !cmd_ready) begin
                    if (stall_prev) chk("stall_stable", 32'(got_c), 32'(held));
                    held = got_c;
                    stall_prev = 1'b1;
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
    end

    initial begin
        #2;
        check_all_zero("reset");
        step();
        rstn = 1'b1;
        step();

        // Smallest geometry, TLAST on the final beat
        start_run(2, 4);
        drive_beats(4, 3);
        finish_run(1'b0);

        // Two groups per pixel, no TLAST at all
        start_run(4, 8);
        drive_beats(32, -1);
        finish_run(1'b0);

        // Same run under random backpressure
        rand_rdy = 1'b1;
        start_run(4, 8);
        drive_beats(32, -1);
        finish_run(1'b0);
        rand_rdy = 1'b0;
        step();

        // Early TLAST on beat 7: stream closes with error
        start_run(4, 4);
        drive_beats(7, 6);
        s_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("early_no_ready", 32'(s_ready), 32'd0);
        end
        step();
        finish_run(1'b1);

        // Invalid configurations
        invalid_cfg(3, 8);
        invalid_cfg(4, 6);

        // Asynchronous abort mid-run, then a clean run
        start_run(4, 8);
        drive_beats(10, -1);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        s_valid = 1'b1;
        #1 rstn = 1'b0;
        #1 check_all_zero("abort");
        s_valid = 1'b0;
        start   = 1'b0;
        exp_q.delete();
        step();
        rstn = 1'b1;
        repeat (3) step();
        chk("abort_no_done", 32'(done), 32'd0);
        start_run(2, 4);
        drive_beats(4, 3);
        finish_run(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
